// File: rtl/sync_sram_be_dp.sv
// One-read/one-write synchronous SRAM with byte-lane writes, a zero-fill sweep after reset,
// selectable same-address read-during-write policy and an optional output register stage.
module sync_sram_be_dp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_busy,
    output logic              err
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                init_busy_q, init_busy_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                p1_valid_q, p1_valid_d;
    logic [DATA_W-1:0]   p1_data_q, p1_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_q, err_d;

    logic                run_s;
    logic                wr_acc_s, rd_acc_s;
    logic                wr_in_s, rd_in_s;
    logic                wr_en_s;
    logic [IDX_W-1:0]    wr_idx_s, rd_idx_s, init_idx_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                out_valid_s;
    logic [DATA_W-1:0]   out_data_s;

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign run_s      = (state_q == ST_RUN);
    assign wr_acc_s   = run_s & cs & we;
    assign rd_acc_s   = run_s & cs & rd;
    assign wr_in_s    = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_s    = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_en_s    = wr_acc_s & wr_in_s;
    assign wr_idx_s   = wr_addr[IDX_W-1:0];
    assign rd_idx_s   = rd_addr[IDX_W-1:0];
    assign init_idx_s = init_cnt_q[IDX_W-1:0];

    // Clear-sweep sequencing: one word per cycle, then park in RUN.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_cnt_d  = {ADDR_W{1'b0}};
                    init_busy_d = 1'b0;
                end else begin
                    state_d     = ST_INIT;
                    init_cnt_d  = init_cnt_q + ADDR_W'(1'b1);
                    init_busy_d = 1'b1;
                end
            end
            ST_RUN: begin
                state_d     = ST_RUN;
                init_busy_d = 1'b0;
            end
            default: begin
                state_d     = ST_INIT;
                init_cnt_d  = {ADDR_W{1'b0}};
                init_busy_d = 1'b1;
            end
        endcase
    end

    // Sweep state and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= {ADDR_W{1'b0}};
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Read word; out-of-range reads return zero, new-data policy forwards the merged write.
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        if (rd_in_s) begin
            if ((RDW_MODE != 0) && wr_en_s && (wr_addr == rd_addr)) begin
                rd_word_s = merge_lanes(mem_q[rd_idx_s], wr_data, wr_be);
            end else begin
                rd_word_s = mem_q[rd_idx_s];
            end
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
    end

    // Read pipeline next-state; rd_data holds whenever nothing completes.
    always_comb begin
        p1_valid_d = rd_acc_s;
        p1_data_d  = p1_data_q;
        if (rd_acc_s) begin
            p1_data_d = rd_word_s;
        end else begin
            p1_data_d = p1_data_q;
        end

        if (OUT_REG != 0) begin
            out_valid_s = p1_valid_q;
            out_data_s  = p1_data_q;
        end else begin
            out_valid_s = rd_acc_s;
            out_data_s  = rd_word_s;
        end

        rd_valid_d = out_valid_s;
        if (out_valid_s) begin
            rd_data_d = out_data_s;
        end else begin
            rd_data_d = rd_data_q;
        end

        err_d = (wr_acc_s & ~wr_in_s) | (rd_acc_s & ~rd_in_s);
    end

    // Read pipeline and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_data_q  <= p1_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    // Storage array: no reset, cleared only by the sweep.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[init_idx_s] <= {DATA_W{1'b0}};
        end else if (wr_en_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx_s][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = init_busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sync_sram_be_dp.sv
// Drives two differently-configured SRAM instances from one shared request bus and checks
// them against an array/queue reference model plus directed expected constants.
module tb_sync_sram_be_dp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs, we, rd;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic [7:0]  a_rd_data;
    logic        a_rd_valid, a_init_busy, a_err;
    logic [31:0] b_rd_data;
    logic        b_rd_valid, b_init_busy, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: 8-bit, 16 words, old-data, latency 1.  B: 32-bit, 200 words, new-data, latency 2.
    sync_sram_be_dp #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .RDW_MODE(0), .OUT_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]), .rd(rd), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .init_busy(a_init_busy), .err(a_err));

    sync_sram_be_dp #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1), .OUT_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd(rd), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .init_busy(b_init_busy), .err(b_err));

    typedef struct {
        int          due;
        logic [31:0] data;
    } item_t;

    logic [7:0]  ma [16];
    logic [31:0] mb [200];
    item_t       qa [$];
    item_t       qb [$];
    int          cyc = 0;
    int          sa = 0;
    int          sb = 0;
    logic        ea_valid = 1'b0, ea_err = 1'b0, ea_busy = 1'b1;
    logic        eb_valid = 1'b0, eb_err = 1'b0, eb_busy = 1'b1;
    logic [7:0]  ea_data = 8'h00;
    logic [31:0] eb_data = 32'h0;

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic idle();
        cs = 1'b0; we = 1'b0; rd = 1'b0;
        wr_addr = 8'h00; rd_addr = 8'h00; wr_data = 32'h0; wr_be = 4'h0;
    endtask

    // One clock edge: advance the reference model with the inputs sampled at that edge.
    task automatic step();
        logic [31:0] va, vb;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            sa = 0; sb = 0; qa.delete(); qb.delete();
            ea_valid = 1'b0; ea_err = 1'b0; ea_busy = 1'b1; ea_data = 8'h00;
            eb_valid = 1'b0; eb_err = 1'b0; eb_busy = 1'b1; eb_data = 32'h0;
        end else begin
            ea_valid = 1'b0; ea_err = 1'b0;
            if (sa < 16) begin
                ma[sa] = 8'h00; sa++;
            end else begin
                if (cs && rd) begin
                    va = (rd_addr < 16) ? {24'h0, ma[rd_addr[3:0]]} : 32'h0;
                    qa.push_back('{cyc, va});
                end
                if (cs && we && wr_addr < 16 && wr_be[0]) ma[wr_addr[3:0]] = wr_data[7:0];
                ea_err = cs && ((we && wr_addr >= 16) || (rd && rd_addr >= 16));
            end
            if (qa.size() > 0 && qa[0].due == cyc) begin
                ea_valid = 1'b1; ea_data = qa[0].data[7:0]; void'(qa.pop_front());
            end
            ea_busy = (sa < 16);

            eb_valid = 1'b0; eb_err = 1'b0;
            if (sb < 200) begin
                mb[sb] = 32'h0; sb++;
            end else begin
                if (cs && rd) begin
                    vb = (rd_addr < 200) ? mb[rd_addr] : 32'h0;
                    if (we && wr_addr < 200 && wr_addr == rd_addr) vb = merge_ref(vb, wr_data, wr_be);
                    qb.push_back('{cyc + 1, vb});
                end
                if (cs && we && wr_addr < 200) mb[wr_addr] = merge_ref(mb[wr_addr], wr_data, wr_be);
                eb_err = cs && ((we && wr_addr >= 200) || (rd && rd_addr >= 200));
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                eb_valid = 1'b1; eb_data = qb[0].data; void'(qb.pop_front());
            end
            eb_busy = (sb < 200);
        end
        #1;
    endtask

    // Runs right after reset release: measures cycles until each instance leaves the sweep.
    task automatic run_sweep(input bit poke, output int fa, output int fb, output int bad);
        fa = 0; fb = 0; bad = 0;
        for (int k = 1; k <= 260; k++) begin
            if (poke && k >= 5 && k <= 12) begin
                cs = 1'b1; we = 1'b1; rd = 1'b1; wr_be = 4'hF; wr_data = $urandom;
                wr_addr = 8'($urandom_range(0, 3)); rd_addr = 8'($urandom_range(0, 255));
            end else begin
                idle();
            end
            step();
            if (fa != 0 && a_init_busy !== 1'b0) bad++;
            if (fa == 0 && a_init_busy === 1'b0) fa = k;
            if (fb == 0 && b_init_busy === 1'b0) fb = k;
            if (a_rd_valid !== 1'b0 || a_err !== 1'b0 || b_rd_valid !== 1'b0 || b_err !== 1'b0) bad++;
            if (fb != 0) break;
        end
        idle();
    endtask

    task automatic test_reset();
        int fa, fb, bad;
        idle(); rst_n = 1'b0;
        step(); step();
        checks++;
        if ({a_rd_valid, a_err, a_init_busy} !== 3'b001 || a_rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_state_a: got v/e/b=%b%b%b data=%h, want 001 data=00", a_rd_valid, a_err, a_init_busy, a_rd_data);
        end
        checks++;
        if ({b_rd_valid, b_err, b_init_busy} !== 3'b001 || b_rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_state_b: got v/e/b=%b%b%b data=%h, want 001 data=0", b_rd_valid, b_err, b_init_busy, b_rd_data);
        end
        rst_n = 1'b1;
        run_sweep(1'b1, fa, fb, bad);
        checks++;
        if (fa != 16) begin errors++; $display("FAIL sweep_len_a: got %0d cycles, want 16", fa); end
        checks++;
        if (fb != 200) begin errors++; $display("FAIL sweep_len_b: got %0d cycles, want 200", fb); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sweep_quiet: got %0d bad cycles, want 0", bad); end
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin cs = 1'b1; rd = 1'b1; rd_addr = 8'(k); end else idle();
            step();
            if (k < 16) begin
                checks++;
                if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
                    errors++; $display("FAIL cleared_a[%0d]: got v=%b d=%h, want v=1 d=00", k, a_rd_valid, a_rd_data);
                end
            end
            if (k >= 1) begin
                checks++;
                if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h0) begin
                    errors++; $display("FAIL cleared_b[%0d]: got v=%b d=%h, want v=1 d=0", k - 1, b_rd_valid, b_rd_data);
                end
            end
        end
        step();
    endtask

    task automatic test_byte_enable();
        idle(); cs = 1'b1; we = 1'b1; wr_addr = 8'd10;
        wr_data = 32'hAABBCCDD; wr_be = 4'hF; step();
        wr_data = 32'h11223344; wr_be = 4'b0101; step();
        wr_data = 32'hFFFFFFFF; wr_be = 4'h0; step();
        we = 1'b0; rd = 1'b1; rd_addr = 8'd10; step();
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h44) begin
            errors++; $display("FAIL be_merge_a: got v=%b d=%h, want v=1 d=44", a_rd_valid, a_rd_data);
        end
        idle(); step();
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'hAA22CC44) begin
            errors++; $display("FAIL be_merge_b: got v=%b d=%h, want v=1 d=aa22cc44", b_rd_valid, b_rd_data);
        end
        checks++;
        if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h44) begin
            errors++; $display("FAIL hold_a: got v=%b d=%h, want v=0 d=44", a_rd_valid, a_rd_data);
        end
    endtask

    task automatic test_rdw();
        idle(); cs = 1'b1; we = 1'b1; wr_addr = 8'd5; wr_data = 32'h33; wr_be = 4'hF; step();
        wr_data = 32'h77; rd = 1'b1; rd_addr = 8'd5; step();
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h33) begin
            errors++; $display("FAIL rdw_old_a: got v=%b d=%h, want v=1 d=33", a_rd_valid, a_rd_data);
        end
        wr_data = 32'hDEAD0000; wr_be = 4'b1100; step();
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h00000077) begin
            errors++; $display("FAIL rdw_new_b: got v=%b d=%h, want v=1 d=00000077", b_rd_valid, b_rd_data);
        end
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h77) begin
            errors++; $display("FAIL rdw_after_a: got v=%b d=%h, want v=1 d=77", a_rd_valid, a_rd_data);
        end
        idle(); step();
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'hDEAD0077) begin
            errors++; $display("FAIL rdw_merge_b: got v=%b d=%h, want v=1 d=dead0077", b_rd_valid, b_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        for (int k = 1; k <= 3; k++) begin
            d[k] = $urandom;
            idle(); cs = 1'b1; we = 1'b1; wr_addr = 8'(k); wr_data = d[k]; wr_be = 4'hF; step();
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin idle(); cs = 1'b1; rd = 1'b1; rd_addr = 8'(k + 1); end else idle();
            step();
            checks++;
            if (k < 3) begin
                if (a_rd_valid !== 1'b1 || a_rd_data !== d[k + 1][7:0]) begin
                    errors++; $display("FAIL b2b_a[%0d]: got v=%b d=%h, want v=1 d=%h", k, a_rd_valid, a_rd_data, d[k + 1][7:0]);
                end
            end else if (a_rd_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_a_idle[%0d]: got v=%b, want v=0", k, a_rd_valid);
            end
            checks++;
            if (k >= 1 && k <= 3) begin
                if (b_rd_valid !== 1'b1 || b_rd_data !== d[k]) begin
                    errors++; $display("FAIL b2b_b[%0d]: got v=%b d=%h, want v=1 d=%h", k, b_rd_valid, b_rd_data, d[k]);
                end
            end else if (b_rd_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_b_idle[%0d]: got v=%b, want v=0", k, b_rd_valid);
            end
        end
    endtask

    task automatic test_out_of_range();
        idle(); cs = 1'b1; we = 1'b1; wr_addr = 8'd10; wr_data = 32'h12345678; wr_be = 4'hF; step();
        wr_addr = 8'd250; wr_data = 32'hFFFFFFFF; step();
        checks++;
        if (a_err !== 1'b1 || b_err !== 1'b1) begin
            errors++; $display("FAIL oor_wr_err: got a=%b b=%b, want 1 1", a_err, b_err);
        end
        idle(); cs = 1'b1; rd = 1'b1; rd_addr = 8'd10; step();
        checks++;
        if (a_err !== 1'b0 || b_err !== 1'b0 || a_rd_valid !== 1'b1 || a_rd_data !== 8'h78) begin
            errors++; $display("FAIL oor_wr_drop_a: got err=%b/%b v=%b d=%h, want 0/0 v=1 d=78", a_err, b_err, a_rd_valid, a_rd_data);
        end
        rd_addr = 8'd250; step();
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h12345678) begin
            errors++; $display("FAIL oor_wr_drop_b: got v=%b d=%h, want v=1 d=12345678", b_rd_valid, b_rd_data);
        end
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00 || a_err !== 1'b1 || b_err !== 1'b1) begin
            errors++; $display("FAIL oor_rd_a: got v=%b d=%h err=%b/%b, want v=1 d=00 err=1/1", a_rd_valid, a_rd_data, a_err, b_err);
        end
        idle(); step();
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h0 || a_err !== 1'b0 || b_err !== 1'b0) begin
            errors++; $display("FAIL oor_rd_b: got v=%b d=%h err=%b/%b, want v=1 d=0 err=0/0", b_rd_valid, b_rd_data, a_err, b_err);
        end
    endtask

    task automatic test_reset_mid();
        int fa, fb, bad;
        idle(); rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int k = 0; k < 7; k++) step();
        rst_n = 1'b0; #2;
        checks++;
        if (a_init_busy !== 1'b1 || b_init_busy !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_busy: got a=%b b=%b, want 1 1", a_init_busy, b_init_busy);
        end
        step(); rst_n = 1'b1;
        run_sweep(1'b0, fa, fb, bad);
        checks++;
        if (fa != 16 || fb != 200 || bad != 0) begin
            errors++; $display("FAIL sweep_restart: got a=%0d b=%0d bad=%0d, want 16 200 0", fa, fb, bad);
        end
        cs = 1'b1; rd = 1'b1; rd_addr = 8'd3; step();
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
            errors++; $display("FAIL pre_abort_a: got v=%b d=%h, want v=1 d=00", a_rd_valid, a_rd_data);
        end
        idle(); rst_n = 1'b0; #2;
        checks++;
        if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0) begin
            errors++; $display("FAIL abort_async: got a=%b b=%b, want 0 0", a_rd_valid, b_rd_valid);
        end
        step();
        checks++;
        if (b_rd_valid !== 1'b0 || b_init_busy !== 1'b1) begin
            errors++; $display("FAIL abort_read_b: got v=%b busy=%b, want v=0 busy=1", b_rd_valid, b_init_busy);
        end
        rst_n = 1'b1;
        run_sweep(1'b0, fa, fb, bad);
        checks++;
        if (fa != 16 || fb != 200 || bad != 0) begin
            errors++; $display("FAIL sweep_after_abort: got a=%0d b=%0d bad=%0d, want 16 200 0", fa, fb, bad);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 402; k++) begin
            if (k < 400) begin
                cs = ($urandom_range(0, 7) != 0);
                we = 1'($urandom_range(0, 1));
                rd = 1'($urandom_range(0, 1));
                wr_be = 4'($urandom_range(0, 15));
                wr_data = $urandom;
                wr_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
                rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr :
                          (($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19)));
            end else begin
                idle();
            end
            step();
            checks++;
            if (a_rd_valid !== ea_valid || a_rd_data !== ea_data || a_err !== ea_err || a_init_busy !== ea_busy) begin
                errors++; $display("FAIL rand_a[%0d]: got v=%b d=%h e=%b b=%b, want v=%b d=%h e=%b b=%b",
                    k, a_rd_valid, a_rd_data, a_err, a_init_busy, ea_valid, ea_data, ea_err, ea_busy);
            end
            checks++;
            if (b_rd_valid !== eb_valid || b_rd_data !== eb_data || b_err !== eb_err || b_init_busy !== eb_busy) begin
                errors++; $display("FAIL rand_b[%0d]: got v=%b d=%h e=%b b=%b, want v=%b d=%h e=%b b=%b",
                    k, b_rd_valid, b_rd_data, b_err, b_init_busy, eb_valid, eb_data, eb_err, eb_busy);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
